mem8x8_arbiter: RTL and testbench

- Two-port access controller/arbiter for the 8x8 memory array.
- Shares the single memory port between requesters A and B with round-robin priority.
- Sequences each access onto the memory control lines: word select via the 1-to-8 write demux, write strobe, and tri-state read enable.
- Captures read data and returns a one-cycle acknowledge to the winning requester.

---
 rtl/mem8x8_arbiter_pkg.sv | 21 ++
 rtl/mem8x8_arbiter_rr.sv | 23 ++
 rtl/mem8x8_arbiter.sv | 130 +++++++++++++
 tb/tb_mem8x8_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem8x8_arbiter_pkg.sv
// Shared definitions for the 8x8 memory arbiter: FSM encodings, requester IDs,
// default geometry and a small saturating-increment helper.
package mem8x8_arbiter_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem8x8_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin pick. On a tie the requester
// that did not win last time is chosen.
module rr_arbiter2
    import mem8x8_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_gnt,
    output logic gnt_id,
    output logic any_req
);

    always_comb begin
        any_req = req_a | req_b;
        gnt_id  = ID_A;
        if (req_a && req_b) begin
            gnt_id = ~last_gnt;
        end else if (req_b) begin
            gnt_id = ID_B;
        end
    end

endmodule

// File: rtl/mem8x8_arbiter.sv
// Two-port round-robin access controller for the 8x8 memory array.
// Optional per-requester grant counters are enabled with MEM8X8_ARB_STAT_EN.
module mem8x8_arbiter
    import mem8x8_arbiter_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_adr,
    output logic          mem_wr,
    output logic          mem_oe,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [7:0]    stat_a,
    output logic [7:0]    stat_b
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_gnt;
    logic       win_id;
    logic       we_r;
    logic [3:0] cnt;
    logic       gnt_id;
    logic       any_req;
    logic       acc_done;

    rr_arbiter2 u_rr (
        .req_a    (a_req),
        .req_b    (b_req),
        .last_gnt (last_gnt),
        .gnt_id   (gnt_id),
        .any_req  (any_req)
    );

    assign acc_done = (state == ACC) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACC;
            ACC:     if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant-time sampling: the winner's fields are frozen here so a requester
    // may change its inputs while the access is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_adr  <= '0;
            mem_din  <= '0;
            we_r     <= 1'b0;
            win_id   <= ID_A;
            last_gnt <= ID_B;
            cnt      <= 4'd0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                win_id  <= gnt_id;
                we_r    <= (gnt_id == ID_B) ? b_we    : a_we;
                mem_adr <= (gnt_id == ID_B) ? b_adr   : a_adr;
                mem_din <= (gnt_id == ID_B) ? b_wdata : a_wdata;
                cnt     <= CNT_LOAD;
            end
            if (state == ACC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc_done && !we_r) begin
                if (win_id == ID_B) begin
                    b_rdata <= mem_dout;
                end else begin
                    a_rdata <= mem_dout;
                end
            end
            if (state == RESP) begin
                last_gnt <= win_id;
            end
        end
    end

    // Strobes decode straight from the state so a reset drops them at once.
    assign mem_wr = (state == ACC) &  we_r;
    assign mem_oe = (state == ACC) & ~we_r;
    assign a_ack  = (state == RESP) && (win_id == ID_A);
    assign b_ack  = (state == RESP) && (win_id == ID_B);

`ifdef MEM8X8_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_a <= 8'd0;
            stat_b <= 8'd0;
        end else begin
            if (a_ack) stat_a <= sat_inc8(stat_a);
            if (b_ack) stat_b <= sat_inc8(stat_b);
        end
    end
`else
    assign stat_a = 8'd0;
    assign stat_b = 8'd0;
`endif

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Self-checking bench for mem8x8_arbiter: a WAIT_CYC=1 instance with a bus-level
// memory model and scoreboard, plus a WAIT_CYC=3 instance for strobe length.
module tb_mem8x8_arbiter;

    typedef struct {
        logic       id;
        logic       we;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_adr, b_adr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic [2:0] mem_adr;
    logic       mem_wr, mem_oe;
    logic [7:0] mem_din, mem_dout;
    logic [7:0] stat_a, stat_b;

    logic       w3_a_req, w3_a_we, w3_b_req, w3_b_we;
    logic [2:0] w3_a_adr, w3_b_adr;
    logic [7:0] w3_a_wdata, w3_b_wdata;
    logic       w3_a_ack, w3_b_ack;
    logic [7:0] w3_a_rdata, w3_b_rdata;
    logic [2:0] w3_mem_adr;
    logic       w3_mem_wr, w3_mem_oe;
    logic [7:0] w3_mem_din, w3_mem_dout;
    logic [7:0] w3_stat_a, w3_stat_b;

    logic [7:0] mem_model [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] ref_mem   [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    mem8x8_arbiter #(.DW(8), .AW(3), .WAIT_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_adr(mem_adr), .mem_wr(mem_wr), .mem_oe(mem_oe),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .stat_a(stat_a), .stat_b(stat_b)
    );

    mem8x8_arbiter #(.DW(8), .AW(3), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(w3_a_req), .a_we(w3_a_we), .a_adr(w3_a_adr), .a_wdata(w3_a_wdata),
        .a_ack(w3_a_ack), .a_rdata(w3_a_rdata),
        .b_req(w3_b_req), .b_we(w3_b_we), .b_adr(w3_b_adr), .b_wdata(w3_b_wdata),
        .b_ack(w3_b_ack), .b_rdata(w3_b_rdata),
        .mem_adr(w3_mem_adr), .mem_wr(w3_mem_wr), .mem_oe(w3_mem_oe),
        .mem_din(w3_mem_din), .mem_dout(w3_mem_dout),
        .stat_a(w3_stat_a), .stat_b(w3_stat_b)
    );

    // Bus-level memory array driven only by the DUT's strobes.
    always @(posedge clk) if (mem_wr) mem_model[mem_adr] <= mem_din;
    assign mem_dout = mem_oe ? mem_model[mem_adr] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_acks"},  {a_ack, b_ack}, 0);
        chk({tag, "_strb"},  {mem_wr, mem_oe}, 0);
        chk({tag, "_adr"},   mem_adr, 0);
        chk({tag, "_din"},   mem_din, 0);
        chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
        chk({tag, "_stat"},  {stat_a, stat_b}, 0);
    endtask

    // Scoreboard consumer: every ack must match the next expected grant.
    always @(posedge clk) begin
        #1;
        if (a_ack || b_ack) begin
            chk("ack_onehot", a_ack & b_ack, 0);
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("ack_id", b_ack, mon_e.id);
                if (!mon_e.we) chk("rdata", mon_e.id ? b_rdata : a_rdata, mon_e.rdata);
            end
        end
    end

    task automatic push_exp(input logic id, input logic we, input logic [2:0] adr, input logic [7:0] wd);
        exp_t e;
        e.id    = id;
        e.we    = we;
        e.rdata = we ? 8'h00 : ref_mem[adr];
        if (we) ref_mem[adr] = wd;
        sb.push_back(e);
    endtask

    // Single-requester access on the WAIT_CYC=1 instance, entered with the DUT idle.
    task automatic applyStimulus(input logic id, input logic we, input logic [2:0] adr, input logic [7:0] wd);
        int  k;
        bit  got;
        push_exp(id, we, adr, wd);
        if (id) begin
            b_we = we; b_adr = adr; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_adr = adr; a_wdata = wd; a_req = 1'b1;
        end
        tick;
        chk("acc_wr", mem_wr, we);
        chk("acc_oe", mem_oe, !we);
        chk("acc_adr", mem_adr, adr);
        if (we) chk("acc_din", mem_din, wd);
        got = 1'b0;
        for (k = 1; k <= 10; k++) begin
            tick;
            if (id ? b_ack : a_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", got, 1);
        chk("ack_latency", k, 1);
        chk("other_ack", id ? a_ack : b_ack, 0);
        chk("resp_strb", {mem_wr, mem_oe}, 0);
        a_req = 1'b0;
        b_req = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acnt, bcnt, n, na, wrcnt, first_wr, last_wr, ackat;
        int ts[4];
        logic [7:0] exp_sa, exp_sb;

        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_adr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_adr = 0; b_wdata = 0;
        w3_a_req = 0; w3_a_we = 0; w3_a_adr = 0; w3_a_wdata = 0;
        w3_b_req = 0; w3_b_we = 0; w3_b_adr = 0; w3_b_wdata = 0;
        w3_mem_dout = 8'h00;
        repeat (2) tick;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick;

        $display("[TB] A write then B read-back");
        applyStimulus(1'b0, 1'b1, 3'd5, 8'hA5);
        applyStimulus(1'b1, 1'b0, 3'd5, 8'h00);
        applyStimulus(1'b1, 1'b1, 3'd3, 8'h3C);
        applyStimulus(1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd7, 8'h00);

        $display("[TB] WAIT_CYC=3 strobe length");
        w3_a_we = 1; w3_a_adr = 3'd7; w3_a_wdata = 8'h5A; w3_a_req = 1;
        wrcnt = 0; first_wr = 0; last_wr = 0; ackat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k == 1) chk("w3_adr", w3_mem_adr, 7);
            if (w3_mem_wr) begin
                wrcnt++;
                if (first_wr == 0) first_wr = k;
                last_wr = k;
            end
            if (w3_a_ack && ackat == 0) begin
                ackat = k;
                w3_a_req = 0;
            end
            chk("w3_noread", {w3_mem_oe, w3_b_ack}, 0);
        end
        chk("w3_wrcnt", wrcnt, 3);
        chk("w3_first", first_wr, 1);
        chk("w3_last", last_wr, 3);
        chk("w3_ackat", ackat, 4);

        $display("[TB] reset during write access");
        a_we = 1; a_adr = 3'd2; a_wdata = 8'hC3; a_req = 1;
        tick;
        chk("abort_pre_wr", mem_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        a_req = 0;
        repeat (2) begin
            tick;
            chk("abort_noack", {a_ack, b_ack}, 0);
        end
        rst_n = 1'b1;

        $display("[TB] both requesting from reset");
        a_we = 0; a_adr = 3'd5; b_we = 0; b_adr = 3'd3;
        push_exp(1'b0, 1'b0, 3'd5, 8'h00);
        push_exp(1'b1, 1'b0, 3'd3, 8'h00);
        push_exp(1'b0, 1'b0, 3'd5, 8'h00);
        push_exp(1'b1, 1'b0, 3'd3, 8'h00);
        a_req = 1; b_req = 1;
        acnt = 0; bcnt = 0; n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (a_ack || b_ack) begin
                if (n < 4) ts[n] = k;
                n++;
            end
            if (a_ack) begin
                acnt++;
                if (acnt == 2) a_req = 0;
            end
            if (b_ack) begin
                bcnt++;
                if (bcnt == 2) b_req = 0;
            end
            if (acnt == 2 && bcnt == 2) break;
        end
        chk("rr_acnt", acnt, 2);
        chk("rr_bcnt", bcnt, 2);
        chk("rr_n", n, 4);
        chk("rr_first", ts[0], 2);
        for (int i = 1; i < 4; i++) chk("rr_gap", ts[i] - ts[i-1], 3);
        tick;
        applyStimulus(1'b1, 1'b0, 3'd2, 8'h00);

        $display("[TB] grant counters over 300 accesses");
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        na = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 3'(i), 8'h00);
            na++;
        end
`ifdef MEM8X8_ARB_STAT_EN
        exp_sa = (na > 255) ? 8'd255 : 8'(na);
        exp_sb = 8'd0;
`else
        exp_sa = 8'd0;
        exp_sb = 8'd0;
`endif
        chk("checkOutput_stat_a", stat_a, exp_sa);
        chk("checkOutput_stat_b", stat_b, exp_sb);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
